muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative HI/LO multiply/divide unit. One shift-add (multiply) or restoring
// shift-subtract (divide) step per clock on operand magnitudes, followed by a
// single FINISH cycle that applies sign correction and writes Hi/Lo. Latency
// from the Start edge to Done is WIDTH+1 cycles regardless of operand values.
//
// Ports
//   Clock      rising-edge clock
//   Reset      synchronous, active-high; clears control state and Hi/Lo
//   Start      launch operation (sampled only when idle)
//   Op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B       multiplicand/dividend, multiplier/divisor
//   WrHi/WrLo  MTHI/MTLO strobes, honoured only when idle and not starting
//   WData      data for MTHI/MTLO
//   Busy       operation in progress
//   Done       one-cycle completion pulse
//   DivByZero  qualifies Done: divisor was zero (DIV/DIVU only)
//   Hi, Lo     architectural HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WrHi,
    input  logic             WrLo,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] stepCnt;

    // Operation context captured at launch
    logic             isDiv;
    logic             divZero;
    logic             negResult;   // product / quotient must be negated
    logic             negRem;      // remainder takes the dividend's sign
    logic [WIDTH-1:0] dividendRaw; // original A, reported in Hi on divide-by-zero
    logic [WIDTH-1:0] operand;     // multiplicand magnitude or divisor magnitude

    // Shared working registers:
    //   multiply: {accHi, accLo} is the partial product, accLo initially holds
    //             the multiplier and is shifted out one bit per step
    //   divide:   accHi is the partial remainder, accLo holds the dividend
    //             shifting out at the top while quotient bits enter at the bottom
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;

    logic             opSigned;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic             divFits;
    logic [WIDTH-1:0] finHi;
    logic [WIDTH-1:0] finLo;

    // Absolute value for signed ops; the most-negative value maps to its
    // correct unsigned magnitude 2**(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic isSigned);
        if (isSigned && v[WIDTH-1]) begin
            return -v;
        end
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] negateIf(input logic signed [WIDTH-1:0] v,
                                                  input logic neg);
        if (neg) begin
            return -v;
        end
        return v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negateWideIf(input logic signed [2*WIDTH-1:0] v,
                                                        input logic neg);
        if (neg) begin
            return -v;
        end
        return v;
    endfunction

    assign opSigned = ~Op[0];
    assign magA     = magnitude(A, opSigned);
    assign magB     = magnitude(B, opSigned);

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : {(WIDTH + 1){1'b0}});
        divShift = {accHi, accLo[WIDTH-1]};
        divFits  = (divShift >= {1'b0, operand});
    end

    // Sign correction and divide-by-zero override for the FINISH write
    always_comb begin
        finHi = '0;
        finLo = '0;
        if (!isDiv) begin
            {finHi, finLo} = negateWideIf({accHi, accLo}, negResult);
        end else if (divZero) begin
            finHi = dividendRaw;
            finLo = '1;
        end else begin
            finHi = negateIf(accHi, negRem);
            finLo = negateIf(accLo, negResult);
        end
    end

    // Control FSM and architectural registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            stepCnt   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        // A launch swallows any MTHI/MTLO in the same cycle
                        state   <= RUN;
                        Busy    <= 1'b1;
                        stepCnt <= '0;
                    end else begin
                        if (WrHi) Hi <= WData;
                        if (WrLo) Lo <= WData;
                    end
                end
                RUN: begin
                    stepCnt <= stepCnt + CNT_W'(1);
                    if (stepCnt == LAST_STEP) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    Busy      <= 1'b0;
                    Done      <= 1'b1;
                    DivByZero <= divZero;
                    Hi        <= finHi;
                    Lo        <= finLo;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: no reset needed, contents are only consumed after a launch
    always_ff @(posedge Clock) begin
        if (state == IDLE && Start) begin
            isDiv       <= Op[1];
            divZero     <= Op[1] && (B == '0);
            negResult   <= opSigned && (A[WIDTH-1] ^ B[WIDTH-1]);
            negRem      <= opSigned && A[WIDTH-1];
            dividendRaw <= A;
            accHi       <= '0;
            if (Op[1]) begin
                accLo   <= magA;
                operand <= magB;
            end else begin
                accLo   <= magB;
                operand <= magA;
            end
        end else if (state == RUN) begin
            if (isDiv) begin
                // Restoring step: keep the trial subtraction only if it fits
                accHi <= divFits ? WIDTH'(divShift - {1'b0, operand}) : divShift[WIDTH-1:0];
                accLo <= {accLo[WIDTH-2:0], divFits};
            end else begin
                // Shift-add step: add when the current multiplier bit is set,
                // then shift the whole partial product right by one
                accHi <= mulSum[WIDTH:1];
                accLo <= {mulSum[0], accLo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        WrHi;
    logic        WrLo;
    logic [31:0] WData;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int vectors;
    int miscompares;

    // Bench-side copy of the architectural HI/LO contents
    logic [31:0] mHi;
    logic [31:0] mLo;

    muldiv_unit #(.WIDTH(32)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .WrHi      (WrHi),
        .WrLo      (WrLo),
        .WData     (WData),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each operation
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    hi = r[31:0];
                    lo = q[31:0];
                end else begin
                    p = ua / ub;
                    lo = p[31:0];
                    p = ua % ub;
                    hi = p[31:0];
                end
            end
        endcase
    endfunction

    // Launch one operation and follow it cycle by cycle to completion.
    // Disturbs operands after launch, and tries Start/MTHI/MTLO mid-run and
    // in the FINISH cycle; all of those must have no effect.
    task automatic doOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit wrAtStart);
        logic [31:0] eHi, eLo;
        logic        eDz;
        model(op, a, b, eHi, eLo, eDz);
        @(negedge Clock);
        Start = 1'b1; Op = op; A = a; B = b;
        if (wrAtStart) begin
            WrHi = 1'b1; WrLo = 1'b1; WData = $urandom;
        end
        @(posedge Clock); #1;
        Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
        A = $urandom; B = $urandom; Op = 2'($urandom);
        check("launch_ctl", {Busy, Done, DivByZero}, 3'b100);
        check("launch_hold", {Hi, Lo}, {mHi, mLo});
        for (int c = 1; c <= 32; c++) begin
            @(posedge Clock); #1;
            Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
            check("run_ctl", {Busy, Done, DivByZero}, 3'b100);
            check("run_hold", {Hi, Lo}, {mHi, mLo});
            if (c == 10 || c == 32) begin
                Start = 1'b1; WrHi = 1'b1; WrLo = 1'b1; WData = $urandom;
                A = $urandom; B = $urandom; Op = 2'($urandom);
            end
        end
        @(posedge Clock); #1;
        Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
        check("done_ctl", {Busy, Done, DivByZero}, {2'b01, eDz});
        check("done_hi", Hi, eHi);
        check("done_lo", Lo, eLo);
        mHi = eHi;
        mLo = eLo;
        @(posedge Clock); #1;
        check("after_ctl", {Busy, Done, DivByZero}, 3'b000);
        check("after_hold", {Hi, Lo}, {mHi, mLo});
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        vectors     = 0;
        miscompares = 0;
        Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
        WrHi = 1'b0; WrLo = 1'b0; WData = '0;
        mHi = '0; mLo = '0;

        // Reset wins over Start and MTHI/MTLO
        @(negedge Clock);
        Start = 1'b1; WrHi = 1'b1; WrLo = 1'b1; WData = 32'hA5A5_5A5A;
        @(posedge Clock); #1;
        check("reset_ctl", {Busy, Done, DivByZero}, 3'b000);
        check("reset_hi", Hi, 32'd0);
        check("reset_lo", Lo, 32'd0);
        @(negedge Clock);
        Reset = 1'b0; Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
        @(posedge Clock); #1;
        check("idle_ctl", {Busy, Done, DivByZero}, 3'b000);

        // MTHI alone, then both in one cycle
        @(negedge Clock);
        WrHi = 1'b1; WData = 32'h0000_1234;
        @(posedge Clock); #1;
        WrHi = 1'b0;
        mHi = 32'h0000_1234;
        check("mthi_hi", Hi, mHi);
        check("mthi_lo", Lo, mLo);
        @(negedge Clock);
        WrHi = 1'b1; WrLo = 1'b1; WData = 32'hCAFE_F00D;
        @(posedge Clock); #1;
        WrHi = 1'b0; WrLo = 1'b0;
        mHi = 32'hCAFE_F00D; mLo = 32'hCAFE_F00D;
        check("mthilo_hi", Hi, mHi);
        check("mthilo_lo", Lo, mLo);

        // Directed boundary vectors; first one launches alongside MTHI/MTLO
        doOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        doOp(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        doOp(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        doOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        doOp(2'b11, 32'd100, 32'd0, 1'b0);
        doOp(2'b10, 32'hFFFF_FF9C, 32'd0, 1'b0);
        doOp(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        doOp(2'b11, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // Abort mid-run: Start/MTLO ignored at cycle 10, Reset at cycle 12
        @(negedge Clock);
        Start = 1'b1; Op = 2'b01; A = 32'd5; B = 32'd6;
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge Clock); #1;
            Start = 1'b0; WrLo = 1'b0;
            if (c == 10) begin
                Start = 1'b1; WrLo = 1'b1; WData = 32'h0BAD_0BAD;
            end
            if (c == 11) begin
                check("abort_prelo", Lo, mLo);
                Reset = 1'b1;
            end
        end
        @(posedge Clock); #1;
        Reset = 1'b0;
        mHi = '0; mLo = '0;
        check("abort_ctl", {Busy, Done, DivByZero}, 3'b000);
        check("abort_hi", Hi, 32'd0);
        check("abort_lo", Lo, 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(posedge Clock); #1;
            check("abort_quiet", {Busy, Done, DivByZero, Hi, Lo}, 67'd0);
        end
        doOp(2'b01, 32'd5, 32'd6, 1'b0);

        // Randomized operations with a bias toward edge operands
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 5);
                3: ra = $urandom_range(0, 9);
                4: rb = -$urandom_range(1, 5);
                default: ;
            endcase
            doOp(rop, ra, rb, (i % 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
